seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Passive receiver for a multiplexed, active-low 4-digit 7-segment display bus: watches the segment and anode lines that the display driver produces and recovers the BCD digit shown in each position. It sits on the far side of the BCD-to-segment decoding path, for on-board self-check of the digital clock and as a bench monitor. Stability filtering rejects ghosting during anode transitions, and a full-frame handshake presents all four digits coherently.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (legal range 1..255)
- TIMEOUT_CYCLES, 100000, cycles with no single anode active before `stale` asserts (≥2)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, one reset domain
- seg_in  input  7  segment lines, active low, bit 6 = a … bit 0 = g
- an_in  input  4  anode enables, active low, an_in[0] = rightmost digit
- digits  output  16  captured BCD, digit k at [4k+3:4k]; reset 16'h0000
- blank  output  4  digit k showed all segments off; reset 4'b0000
- err  output  4  digit k showed a non-decodable pattern; reset 4'b0000
- frame_valid  output  1  one-cycle pulse: all four digits refreshed since last pulse; reset 0
- stale  output  1  no valid scan for TIMEOUT_CYCLES; reset 0

## Operation
- Inputs pass through a 2-flop synchronizer (sync1, sync2); all decisions use sync2.
- Pattern map (active low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, blank=1111111. Any other pattern is an error.
- FSM states: IDLE, TRACK, HOLD.
- IDLE: if sync2 anode is one-hot-low, latch {an, seg} as candidate, cnt=1, go to TRACK (if STABLE_CYCLES=1, accept immediately and go to HOLD).
- TRACK: when the sample equals the candidate, cnt++; on reaching STABLE_CYCLES, accept and go to HOLD. On a differing one-hot sample, reload the candidate, cnt=1, and stay in TRACK. On a non-one-hot sample, go to IDLE.
- HOLD: while the sample equals the candidate, stay. On any change, act as IDLE on that same cycle (re-evaluate the sample).
- Accept for digit k: decimal → digits[k]=value, blank[k]=0, err[k]=0. Blank → digits[k]=4'hF, blank[k]=1, err[k]=0. Illegal → digits[k] unchanged, err[k]=1, blank[k]=0. In every case set seen[k].
- Accept with seen already 1111 after the set: pulse frame_valid and clear seen to 0000 in the same cycle. The accepted digit counts toward the completed frame.
- Zero or ≥2 anodes low: never accepted; they count toward the timeout.
- Timeout counter: cleared on every cycle with a one-hot anode sample. Saturates at TIMEOUT_CYCLES; `stale`=1 while saturated. Clears on the next one-hot sample, so `stale` drops the following cycle.
- Width: cnt is 8 bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Input change at edge t is visible in sync2 after edge t+2.
- Accept cycle is t+2+STABLE_CYCLES-1; digits/blank/err update at t+2+STABLE_CYCLES (t+6 with default).
- frame_valid asserts in the same cycle the fourth digit's registers update.
- Reset mid-operation: next cycle all outputs are at reset values, FSM=IDLE, seen=0, synchronizers cleared, counters zero. Cleared sync registers read as "all anodes low" (illegal), so there is no spurious accept.
- A glitch shorter than STABLE_CYCLES samples is never accepted.

## Structure
- Package seg7_pkg: SEG_0..SEG_9 and SEG_BLANK localparams, state enum {IDLE, TRACK, HOLD}, DIGITS=4.
- Sub-module seg7_pattern_to_bcd: combinational 7→{valid, blank, bcd[3:0]}, the inverse of the existing segment decoder. Verified standalone against all 128 inputs.

## Test plan
- Scan 1,2,3,4 (an 1110→1101→1011→0111, 10 cycles each, seg per map) → digits=16'h4321, blank=0, err=0, one frame_valid pulse at the last digit's update.
- an=1110 with seg=0010010 held from edge t → digits[3:0]=2 at t+6, not at t+5. A 3-cycle hold (then blank anodes) → no update.
- Digit 2 shows 1111111, digit 1 shows 1010101 → blank=0100, digits[11:8]=F, err=0010, digits[7:4] keeps its previous value.
- an=1100 for 20 cycles mid-scan → no accepts; seen unchanged.
- an=1111 for TIMEOUT_CYCLES (set to 16) → stale=1 after 16 illegal samples; first one-hot sample → stale=0 one cycle later.
- Assert reset for 1 cycle while in TRACK with seen=0111 → all outputs zero next cycle; a subsequent full scan needs all four digits before frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
package seg7_pkg;

  localparam int DIGITS = 4;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // True when exactly one anode line is driven low
  function automatic logic is_one_hot_low(input logic [DIGITS-1:0] an);
    logic r;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Position of the single low anode; only meaningful for one-hot-low inputs
  function automatic logic [1:0] low_index(input logic [DIGITS-1:0] an);
    logic [1:0] r;
    case (an)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Inverse segment decoder: maps an active-low 7-segment pattern back to BCD.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] bcd
);

  // Table lookup; blank reports bcd=F, undecodable patterns report valid=0
  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    bcd   = 4'h0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        blank = 1'b1;
        bcd   = 4'hF;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive receiver for a multiplexed active-low 4-digit 7-segment bus.
// Recovers the digit shown in each position after a stability filter and
// signals when all four positions have been refreshed.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  frame_valid,
  output logic                  stale
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     STABLE_N = 8'(STABLE_CYCLES);

  // Synchronizer chain carries {an, seg}; reset value reads as all anodes low
  logic [10:0] sync1_q, sync2_q;

  state_e               state_q, state_d;
  logic [10:0]          cand_q, cand_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  digits_q, digits_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic [DIGITS-1:0]    err_q, err_d;
  logic [DIGITS-1:0]    seen_q, seen_d;
  logic                 fv_q, fv_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;

  logic [DIGITS-1:0]    sample_an;
  logic [6:0]           sample_seg;
  logic                 sample_oh;
  logic                 accept;
  logic                 restart;
  logic [7:0]           cnt_inc;

  logic                 dec_valid;
  logic                 dec_blank;
  logic [3:0]           dec_bcd;

  assign sample_an  = sync2_q[10:7];
  assign sample_seg = sync2_q[6:0];
  assign sample_oh  = is_one_hot_low(sample_an);
  assign cnt_inc    = cnt_q + 8'd1;

  // The accepted pattern is always the current sample, so decode it directly
  seg7_pattern_to_bcd u_dec (
    .seg   (sample_seg),
    .valid (dec_valid),
    .blank (dec_blank),
    .bcd   (dec_bcd)
  );

  // Stability filter: count consecutive identical one-hot samples
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE:  restart = 1'b1;
      TRACK: begin
        if (!sample_oh) begin
          state_d = IDLE;
        end else if (sync2_q == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_N) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end else begin
          restart = 1'b1;
        end
      end
      HOLD:  begin
        // Any change re-evaluates the sample as a fresh candidate this cycle
        if (sync2_q != cand_q) restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      if (sample_oh) begin
        cand_d = sync2_q;
        cnt_d  = 8'd1;
        if (STABLE_N == 8'd1) begin
          accept  = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = TRACK;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Digit capture and frame completion on each accept
  always_comb begin
    logic [1:0]        k;
    logic [DIGITS-1:0] seen_set;
    digits_d = digits_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fv_d     = 1'b0;
    k        = low_index(sample_an);
    seen_set = seen_q | (DIGITS'(1) << k);
    if (accept) begin
      if (dec_valid) begin
        // Decimal digits and blank both carry their bcd code (F for blank)
        digits_d[{k, 2'b00} +: 4] = dec_bcd;
        blank_d[k]                = dec_blank;
        err_d[k]                  = 1'b0;
      end else begin
        blank_d[k] = 1'b0;
        err_d[k]   = 1'b1;
      end
      if (seen_set == {DIGITS{1'b1}}) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_set;
      end
    end
  end

  // Saturating count of samples without a single active anode
  always_comb begin
    tcnt_d = tcnt_q;
    if (sample_oh) begin
      tcnt_d = '0;
    end else if (tcnt_q != T_MAX) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // State register for synchronizers, filter, captured digits and timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      fv_q     <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      sync1_q  <= {an_in, seg_in};
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      fv_q     <= fv_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign stale       = (tcnt_q == T_MAX);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a run-length reference model.
module tb_seg7_scan_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        stale;

  int n_vec  = 0;
  int n_miss = 0;
  int fv_seen = 0;
  int fv_base;
  int cyc = 0;

  seg7_scan_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  // Reference model: a digit is accepted on the cycle its one-hot sample has
  // been seen exactly STABLE times in a row; samples lag the pins by two edges.
  logic [10:0] m_s1, m_s2, m_prev;
  logic [15:0] m_dig;
  logic [3:0]  m_blk, m_err, m_seen;
  logic        m_fv;
  int          m_run, m_t, m_k, m_val;
  logic [3:0]  m_an;
  logic [6:0]  m_sg;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_dig = '0; m_blk = '0; m_err = '0; m_seen = '0; m_fv = 1'b0;
      m_run = 0; m_t = 0;
    end else begin
      m_an = m_s2[10:7];
      m_sg = m_s2[6:0];
      m_fv = 1'b0;
      if ($countones(~m_an) == 1) begin
        if (m_run > 0 && m_s2 == m_prev) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_run = 1;
        end
        m_t = 0;
        if (m_run == STABLE) begin
          m_k = 0;
          for (int i = 0; i < 4; i++) if (!m_an[i]) m_k = i;
          m_val = -1;
          for (int i = 0; i < 10; i++) if (m_sg == PAT[i]) m_val = i;
          if (m_val >= 0) begin
            m_dig[m_k*4 +: 4] = 4'(m_val);
            m_blk[m_k] = 1'b0;
            m_err[m_k] = 1'b0;
          end else if (m_sg == BL) begin
            m_dig[m_k*4 +: 4] = 4'hF;
            m_blk[m_k] = 1'b1;
            m_err[m_k] = 1'b0;
          end else begin
            m_blk[m_k] = 1'b0;
            m_err[m_k] = 1'b1;
          end
          m_seen[m_k] = 1'b1;
          if (m_seen == 4'hF) begin
            m_fv = 1'b1;
            m_seen = 4'h0;
          end
        end
      end else begin
        m_run = 0;
        if (m_t < TIMEOUT) m_t++;
      end
      m_prev = m_s2;
      m_s2 = m_s1;
      m_s1 = {an_in, seg_in};
    end
  end

  // Hold inputs for n cycles, comparing every output against the model each cycle
  task automatic step(input logic [3:0] an, input logic [6:0] sg, input int n);
    logic [25:0] act, exp;
    for (int i = 0; i < n; i++) begin
      an_in  = an;
      seg_in = sg;
      @(negedge clk);
      cyc++;
      if (frame_valid) fv_seen++;
      act = {digits, blank, err, frame_valid, stale};
      exp = {m_dig, m_blk, m_err, m_fv, (m_t == TIMEOUT)};
      n_vec++;
      if (act !== exp) begin
        n_miss++;
        $display("FAIL cycle%0d outputs {digits,blank,err,fv,stale}: got %h want %h",
                 cyc, act, exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    an_in  = 4'hF;
    seg_in = BL;
    step(4'hF, BL, 2);
    reset = 1'b0;
    chk("reset_outputs", {6'd0, digits, blank, err, frame_valid, stale}, 32'd0);

    // Full scan 1,2,3,4
    fv_base = fv_seen;
    step(4'b1110, PAT[1], 10);
    step(4'b1101, PAT[2], 10);
    step(4'b1011, PAT[3], 10);
    step(4'b0111, PAT[4], 10);
    chk("scan_digits", {16'd0, digits}, 32'h4321);
    chk("scan_blank", {28'd0, blank}, 32'h0);
    chk("scan_err", {28'd0, err}, 32'h0);
    chk("scan_frame_pulses", fv_seen - fv_base, 32'd1);

    // Accept latency: update at t+6, not t+5; short hold rejected
    step(4'hF, BL, 5);
    step(4'b1110, PAT[2], 5);
    chk("latency_t5", {16'd0, digits}, 32'h4321);
    step(4'b1110, PAT[2], 1);
    chk("latency_t6", {16'd0, digits}, 32'h4322);
    step(4'b1110, PAT[2], 4);
    step(4'hF, BL, 6);
    step(4'b1110, PAT[7], 3);
    step(4'hF, BL, 6);
    chk("glitch_rejected", {16'd0, digits}, 32'h4322);

    // Blank on digit 2, illegal pattern on digit 1
    step(4'b1011, BL, 10);
    step(4'b1101, 7'b1010101, 10);
    step(4'hF, BL, 6);
    chk("blank_digits", {16'd0, digits}, 32'h4F22);
    chk("blank_flags", {28'd0, blank}, 32'h4);
    chk("err_flags", {28'd0, err}, 32'h2);

    // Two anodes low: no accept, seen retained (0111) so digit 3 completes a frame
    fv_base = fv_seen;
    step(4'b1100, PAT[8], 20);
    chk("multi_anode_digits", {16'd0, digits}, 32'h4F22);
    chk("multi_anode_no_frame", fv_seen - fv_base, 32'd0);
    step(4'b0111, PAT[5], 10);
    chk("seen_kept_frame", fv_seen - fv_base, 32'd1);
    chk("seen_kept_digits", {16'd0, digits}, 32'h5F22);

    // Timeout: stale after 16 illegal samples, drops one cycle after first one-hot sample
    step(4'hF, BL, 17);
    chk("stale_before", {31'd0, stale}, 32'd0);
    step(4'hF, BL, 1);
    chk("stale_set", {31'd0, stale}, 32'd1);
    step(4'b1110, PAT[0], 2);
    chk("stale_held", {31'd0, stale}, 32'd1);
    step(4'b1110, PAT[0], 1);
    chk("stale_cleared", {31'd0, stale}, 32'd0);
    step(4'b1110, PAT[0], 7);

    // Reset while tracking with seen=0111
    step(4'b1101, PAT[6], 10);
    step(4'b1011, PAT[9], 10);
    chk("pre_reset_digits", {16'd0, digits}, 32'h5960);
    step(4'b0111, PAT[3], 4);
    reset = 1'b1;
    step(4'b0111, PAT[3], 1);
    reset = 1'b0;
    chk("mid_reset_outputs", {6'd0, digits, blank, err, frame_valid, stale}, 32'd0);
    step(4'hF, BL, 4);
    fv_base = fv_seen;
    step(4'b1110, PAT[1], 10);
    step(4'b1101, PAT[2], 10);
    step(4'b1011, PAT[3], 10);
    chk("post_reset_no_early_frame", fv_seen - fv_base, 32'd0);
    step(4'b0111, PAT[4], 10);
    chk("post_reset_frame", fv_seen - fv_base, 32'd1);
    chk("post_reset_digits", {16'd0, digits}, 32'h4321);
    step(4'hF, BL, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
